// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: resolves E0/F0 prefixes, tracks left/right arrow
// held/press state and queues every decoded key event in a FWFT FIFO.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FIFO_DEPTH     = 4,
  parameter int ACCEPT_KEYPAD  = 0,
  parameter int ERR_W          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic             byte_error,
  output logic             left_held,
  output logic             right_held,
  output logic             left_press,
  output logic             right_press,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             overflow,
  output logic [ERR_W-1:0] err_count
);
  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRE_E0, PRE_F0, PRE_E0F0} state_t;
  state_t state, state_nxt;

  logic [TMR_W-1:0] tmr;
  logic discard, timeout, is_e0, is_f0;
  logic emit, emit_ext, emit_brk, left_match, right_match;

  assign is_e0   = byte_data == 8'hE0;
  assign is_f0   = byte_data == 8'hF0;
  assign discard = byte_valid && (byte_error || byte_data == 8'h00 || byte_data == 8'hFF);
  // A byte arriving on the timeout cycle is decoded in the current state.
  assign timeout = (state != IDLE) && !byte_valid && (tmr == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (byte_valid) begin
      if (discard)    state_nxt = IDLE;
      else if (is_e0) state_nxt = PRE_E0;
      else if (is_f0) state_nxt = (state == PRE_E0 || state == PRE_E0F0) ? PRE_E0F0 : PRE_F0;
      else            state_nxt = IDLE;
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    emit        = byte_valid && !discard && !is_e0 && !is_f0;
    emit_ext    = (state == PRE_E0) || (state == PRE_E0F0);
    emit_brk    = (state == PRE_F0) || (state == PRE_E0F0);
    left_match  = emit && byte_data == 8'h6B && (emit_ext || ACCEPT_KEYPAD != 0);
    right_match = emit && byte_data == 8'h74 && (emit_ext || ACCEPT_KEYPAD != 0);
  end

  // Every byte (re-)arms the timer, so entry and re-arm share one path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    tmr <= '0;
    else if (byte_valid || state == IDLE || timeout) tmr <= '0;
    else                                           tmr <= tmr + TMR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_held   <= 1'b0;
      right_held  <= 1'b0;
      left_press  <= 1'b0;
      right_press <= 1'b0;
      err_count   <= '0;
    end else begin
      left_press  <= left_match  && !emit_brk && !left_held;
      right_press <= right_match && !emit_brk && !right_held;
      if (left_match)  left_held  <= !emit_brk;
      if (right_match) right_held <= !emit_brk;
      if (discard && err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
    end
  end

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic full, pop, wr_en;

  assign full  = count == (AW+1)'(FIFO_DEPTH);
  assign pop   = ev_valid && ev_ready;
  assign wr_en = emit && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {emit_ext, emit_brk, byte_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (emit && full && !pop) overflow <= 1'b1;
    end
  end

  // Head is masked while empty so the uninitialised storage never leaks out.
  assign ev_valid = count != '0;
  assign ev_code  = ev_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign ev_break = ev_valid ? mem[rd_ptr][8]   : 1'b0;
  assign ev_ext   = ev_valid ? mem[rd_ptr][9]   : 1'b0;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: stimulus pushes expected FIFO events into a
// queue, a negedge monitor pops and compares whenever the head is consumed.
module tb_ps2_key_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_error = 1'b0;
  logic       ev_ready = 1'b1;

  logic       left_held, right_held, left_press, right_press;
  logic       ev_valid, ev_ext, ev_break, overflow;
  logic [7:0] ev_code;
  logic [3:0] err_count;

  logic       k_left_held, k_right_held, k_left_press, k_right_press;
  logic       k_ev_valid, k_ev_ext, k_ev_break, k_overflow;
  logic [7:0] k_ev_code;
  logic [3:0] k_err_count;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_key_decoder #(.TIMEOUT_CYCLES(10), .FIFO_DEPTH(4), .ACCEPT_KEYPAD(0), .ERR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_error(byte_error), .left_held(left_held), .right_held(right_held),
    .left_press(left_press), .right_press(right_press), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
    .overflow(overflow), .err_count(err_count));

  ps2_key_decoder #(.TIMEOUT_CYCLES(10), .FIFO_DEPTH(4), .ACCEPT_KEYPAD(1), .ERR_W(4)) kp (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_error(byte_error), .left_held(k_left_held), .right_held(k_right_held),
    .left_press(k_left_press), .right_press(k_right_press), .ev_valid(k_ev_valid),
    .ev_ready(1'b1), .ev_code(k_ev_code), .ev_ext(k_ev_ext), .ev_break(k_ev_break),
    .overflow(k_overflow), .err_count(k_err_count));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL fifo_unexpected: got %0h expected none", {ev_ext, ev_break, ev_code});
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("fifo_head", {22'd0, ev_ext, ev_break, ev_code}, {22'd0, e});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the following cycle.
  task automatic send(input logic [7:0] b, input logic err = 1'b0);
    byte_valid = 1'b1;
    byte_data  = b;
    byte_error = err;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_error = 1'b0;
  endtask

  task automatic expect_ev(input logic ext, input logic brk, input logic [7:0] code);
    exp_q.push_back({ext, brk, code});
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_ev_valid", ev_valid, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_held"}, {left_held, right_held, left_press, right_press}, 0);
    chk({tag, "_fifo"}, {ev_valid, ev_ext, ev_break, ev_code}, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_err"}, err_count, 0);
  endtask

  initial begin
    idle(3);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(1);

    // Extended left arrow make then break
    send(8'hE0); expect_ev(1, 0, 8'h6B); send(8'h6B);
    chk("left_press_make", left_press, 1);
    chk("left_held_make", left_held, 1);
    idle(1);
    chk("left_press_pulse", left_press, 0);
    send(8'hE0); send(8'hF0); expect_ev(1, 1, 8'h6B); send(8'h6B);
    chk("left_held_break", left_held, 0);
    chk("left_press_break", left_press, 0);

    // Typematic right arrow: one pulse only
    send(8'hE0); expect_ev(1, 0, 8'h74); send(8'h74);
    chk("right_press_1", right_press, 1);
    for (int i = 0; i < 2; i++) begin
      send(8'hE0); expect_ev(1, 0, 8'h74); send(8'h74);
      chk("right_press_rep", right_press, 0);
      chk("right_held_rep", right_held, 1);
    end
    send(8'hE0); send(8'hF0); expect_ev(1, 1, 8'h74); send(8'h74);
    chk("right_held_clr", right_held, 0);

    // Non-extended 6B: keypad only counts when ACCEPT_KEYPAD=1
    expect_ev(0, 0, 8'h6B); send(8'h6B);
    chk("kp0_left_held", left_held, 0);
    chk("kp1_left_held", k_left_held, 1);
    chk("kp1_left_press", k_left_press, 1);
    send(8'hF0); expect_ev(0, 1, 8'h6B); send(8'h6B);
    chk("kp1_left_rel", k_left_held, 0);

    // Byte on the timeout cycle still decodes in the prefix state
    send(8'hE0); idle(9); expect_ev(1, 0, 8'h74); send(8'h74);
    chk("tmo_edge_held", right_held, 1);
    chk("tmo_edge_press", right_press, 1);
    send(8'hE0); send(8'hF0); expect_ev(1, 1, 8'h74); send(8'h74);
    // One cycle later the prefix has been dropped
    send(8'hE0); idle(10); expect_ev(0, 0, 8'h74); send(8'h74);
    chk("tmo_right_held", right_held, 0);
    chk("tmo_err_unchanged", err_count, 0);

    // Discarded bytes
    send(8'hF0, 1'b1); expect_ev(0, 0, 8'h6B); send(8'h6B);
    chk("err_count_1", err_count, 1);
    send(8'h00); send(8'hE0); send(8'hFF);
    chk("err_count_3", err_count, 3);
    expect_ev(0, 0, 8'hE1); send(8'hE1);
    drain();

    // Overflow: 5 makes into a depth-4 FIFO with no consumer
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_ev(0, 0, 8'h1C + 8'(i));
      send(8'h1C + 8'(i));
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_head_stable", {ev_valid, ev_code}, {1'b1, 8'h1C});
    ev_ready = 1'b1;
    expect_ev(0, 0, 8'h21); send(8'h21);
    drain();
    chk("ovf_sticky", overflow, 1);

    // Reset with a pending prefix
    send(8'hE0);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    expect_ev(0, 0, 8'h74); send(8'h74);
    chk("post_reset_right", right_held, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Downstream consumer of the PS/2 receiver stage.
- Takes validated scan-code bytes, with one strobe per received frame, and resolves set-2 prefixes: E0 marks an extended key, F0 marks a break (release).
- Maintains held state and press pulses for the left/right arrow keys, which drive the game-control logic.
- Queues every decoded key event in a small FIFO with a valid/ready handshake for other consumers.

Parameters:
- TIMEOUT_CYCLES, 2000000: clk cycles a prefix state may wait for its next byte before being discarded.
- FIFO_DEPTH, 4: event FIFO entries; must be a power of 2, minimum 2.
- ACCEPT_KEYPAD, 0: when 1, non-extended 6B/74 (keypad 4/6) also act as left/right arrow.
- ERR_W, 4: width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- byte_valid  in  1  one-cycle strobe: byte_data is a complete received frame.
- byte_data  in  8  scan-code byte.
- byte_error  in  1  qualifies byte_valid: frame had a parity or stop-bit error.
- left_held  out  1  left arrow is currently down.
- right_held  out  1  right arrow is currently down.
- left_press  out  1  one-cycle pulse on the left arrow 0->1 transition.
- right_press  out  1  one-cycle pulse on the right arrow 0->1 transition.
- ev_valid  out  1  FIFO head valid.
- ev_ready  in  1  consumer accepts the head.
- ev_code  out  8  head key code, without prefixes.
- ev_ext  out  1  head event carried E0.
- ev_break  out  1  head event carried F0 (release).
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- err_count  out  ERR_W  saturating count of discarded bytes.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, FIFO empty, timeout counter 0. Reset mid-sequence discards any pending prefix.
- Only byte_valid cycles advance the FSM. Byte arrival in cycle N produces registered outputs and the FIFO push in cycle N+1.
- FSM states: IDLE, PRE_E0, PRE_F0, PRE_E0F0.
  - IDLE: E0->PRE_E0; F0->PRE_F0; any other byte emits a make event with ext=0 and stays IDLE.
  - PRE_E0: F0->PRE_E0F0; E0->PRE_E0 with timer re-armed; other emits make with ext=1, then IDLE.
  - PRE_F0: E0->PRE_E0; F0->PRE_F0 with timer re-armed; other emits break with ext=0, then IDLE.
  - PRE_E0F0: E0->PRE_E0; F0->PRE_E0F0 with timer re-armed; other emits break with ext=1, then IDLE.
- Discarded bytes, in any state: byte_error=1, or byte_data 00 or FF (keyboard overrun). Effect: no event, FSM->IDLE, err_count+1, saturating at all-ones.
- E1 (pause prefix) is handled as an ordinary code. No special pause handling.
- Timeout: in any PRE_* state, the counter increments each cycle without byte_valid. It resets to 0 on entry or re-arm. On reaching TIMEOUT_CYCLES-1, FSM->IDLE with no event and no err_count change. A byte arriving in the same cycle as the timeout is decoded in the current state; the byte wins.
- Arrow match: code 6B = left, 74 = right. Requires ext=1, unless ACCEPT_KEYPAD=1, in which case ext is ignored.
  - Make: sets *_held. *_press pulses only if *_held was 0, so typematic repeats raise no pulse.
  - Break: clears *_held and raises no pulse.
  - Events still enter the FIFO regardless of match.
- FIFO: first-word-fall-through.
  - Entry format: {ext, break, code}, 10 bits.
  - Pop when ev_valid & ev_ready. Push when the FSM emits an event.
  - Push into an empty FIFO gives ev_valid=1 in the same cycle as the held/press update (N+1).
  - Full with no pop: the push is dropped and overflow is set. overflow clears only on reset. *_held/*_press still update.
  - Full with simultaneous pop and push: both occur; the count is unchanged.
  - Empty with ev_ready=1: no effect. Pointers wrap modulo FIFO_DEPTH.
- Head outputs are stable while ev_valid=1 and ev_ready=0.

Test Plan:
- Bytes E0,6B then E0,F0,6B -> left_press pulses once at E0,6B+1; left_held goes 1 then 0; FIFO pops {1,0,6B},{1,1,6B}.
- Bytes E0,74 repeated 3 times -> one right_press pulse; right_held stays 1; 3 FIFO events.
- ACCEPT_KEYPAD=0, byte 6B alone -> left_held stays 0; event {0,0,6B} queued. With ACCEPT_KEYPAD=1 -> left_held=1 and left_press pulses.
- ev_ready=0, send 5 makes with FIFO_DEPTH=4 -> 4 entries kept, 5th dropped, overflow=1. Then hold ev_ready=1 and push simultaneously -> no further loss.
- TIMEOUT_CYCLES=10: send E0, wait 10 cycles, send 74 -> event {0,0,74}; right_held stays 0 (ACCEPT_KEYPAD=0).
- Send F0 with byte_error=1, then 6B -> err_count=1; event {0,0,6B} is a make, not a break. Assert rst_n=0 after a lone E0 -> all outputs 0, FSM IDLE.
